// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from stored state; updates, allocation and statistics commit on CLK.
module branch_target_buffer #(
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 2,
   parameter int ADDR_W  = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              hit,
   output logic              predict_taken,
   output logic [ADDR_W-1:0] pred_next_pc,
   input  logic              update_en,
   input  logic [ADDR_W-1:0] update_pc,
   input  logic              update_taken,
   input  logic [ADDR_W-1:0] update_target,
   input  logic              clear,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       mispredict_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_ONE << (CNT_W - 1);
   localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_ONE;

   logic              r_valid  [ENTRIES];
   logic [TAG_W-1:0]  r_tag    [ENTRIES];
   logic [ADDR_W-1:0] r_target [ENTRIES];
   logic [CNT_W-1:0]  r_cnt    [ENTRIES];
   logic [31:0]       r_hit_cnt;
   logic [31:0]       r_mispredict_cnt;

   logic [IDX_W-1:0]  w_lk_idx;
   logic [TAG_W-1:0]  w_lk_tag;
   logic [IDX_W-1:0]  w_up_idx;
   logic [TAG_W-1:0]  w_up_tag;
   logic              w_up_hit;
   logic              w_up_pred_taken;
   logic              w_mispredict;
   logic [CNT_W-1:0]  w_up_cnt_next;
   logic              w_unused_bits;

   function automatic logic [CNT_W-1:0] f_cnt_next(input logic [CNT_W-1:0] c,
                                                   input logic taken);
      if (taken) begin
         return (c == CNT_MAX) ? c : c + CNT_ONE;
      end else begin
         return (c == {CNT_W{1'b0}}) ? c : c - CNT_ONE;
      end
   endfunction

   function automatic logic [31:0] f_sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign w_lk_idx      = lookup_pc[IDX_W+1:2];
   assign w_lk_tag      = lookup_pc[ADDR_W-1:IDX_W+2];
   assign w_up_idx      = update_pc[IDX_W+1:2];
   assign w_up_tag      = update_pc[ADDR_W-1:IDX_W+2];
   assign w_unused_bits = ^{lookup_pc[1:0], update_pc[1:0]};

   // Lookup path: read pre-update state, no bypass from a same-cycle update
   always_comb begin
      hit           = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
      predict_taken = hit && r_cnt[w_lk_idx][CNT_W-1];
      if (predict_taken) begin
         pred_next_pc = r_target[w_lk_idx];
      end else begin
         pred_next_pc = lookup_pc + ADDR_W'(4);
      end
   end

   // Update-side hit, stored prediction and mispredict classification
   always_comb begin
      w_up_hit        = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
      w_up_pred_taken = w_up_hit && r_cnt[w_up_idx][CNT_W-1];
      w_up_cnt_next   = f_cnt_next(r_cnt[w_up_idx], update_taken);
      if (w_up_pred_taken != update_taken) begin
         w_mispredict = 1'b1;
      end else if (update_taken && (r_target[w_up_idx] != update_target)) begin
         w_mispredict = 1'b1;
      end else begin
         w_mispredict = 1'b0;
      end
   end

   // Table state: clear beats update; a not-taken miss leaves the table alone
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_valid  <= '{default: 1'b0};
         r_tag    <= '{default: {TAG_W{1'b0}}};
         r_target <= '{default: {ADDR_W{1'b0}}};
         r_cnt    <= '{default: CNT_WEAK_NT};
      end else if (clear) begin
         r_valid  <= '{default: 1'b0};
      end else if (update_en) begin
         if (w_up_hit) begin
            r_cnt[w_up_idx] <= w_up_cnt_next;
            if (update_taken) begin
               r_target[w_up_idx] <= update_target;
            end
         end else if (update_taken) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= update_target;
            r_cnt[w_up_idx]    <= CNT_WEAK_T;
         end
      end
   end

   // Saturating statistics; a cycle with clear asserted records nothing
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_hit_cnt        <= 32'd0;
         r_mispredict_cnt <= 32'd0;
      end else if (update_en && !clear) begin
         if (w_up_hit) begin
            r_hit_cnt <= f_sat_inc32(r_hit_cnt);
         end
         if (w_mispredict) begin
            r_mispredict_cnt <= f_sat_inc32(r_mispredict_cnt);
         end
      end
   end

   assign hit_cnt        = r_hit_cnt;
   assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of direct-mapped entries; power of two, 2..256.
REQ-002 SHALL have parameter CNT_W, default 2: width of each saturating direction counter, 1..4.
REQ-003 SHALL have parameter ADDR_W, default 32: width of PC and target; IDX_W = log2(ENTRIES); TAG_W = ADDR_W-IDX_W-2.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 nRST  input  1  asynchronous, active-low reset.
REQ-006 lookup_pc  input  ADDR_W  IF-stage fetch address.
REQ-007 hit  output  1  lookup_pc matches a valid entry (combinational).
REQ-008 predict_taken  output  1  hit and counter MSB set.
REQ-009 pred_next_pc  output  ADDR_W  predicted next fetch address.
REQ-010 update_en  input  1  ID-stage branch/jump resolved this cycle; qualified by pipeline write enable externally.
REQ-011 update_pc  input  ADDR_W  address of the resolved branch.
REQ-012 update_taken  input  1  actual outcome.
REQ-013 update_target  input  ADDR_W  actual taken target.
REQ-014 clear  input  1  synchronous invalidate of all entries.
REQ-015 hit_cnt  output  32  number of update_en cycles whose update_pc hit a valid entry.
REQ-016 mispredict_cnt  output  32  number of update_en cycles whose stored prediction (taken/target) disagreed with outcome.

Function
REQ-017 Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-018 Entry SHALL hold valid bit, TAG_W tag, ADDR_W target, CNT_W counter.
REQ-019 hit SHALL be 1 iff indexed entry valid and tag equal to lookup_pc tag.
REQ-020 pred_next_pc SHALL equal stored target when predict_taken=1, else lookup_pc+4 (modulo 2^ADDR_W).
REQ-021 Lookup path SHALL be purely combinational from lookup_pc and stored state; zero-cycle latency.
REQ-022 Update on hit: counter +1 if taken (saturate at 2^CNT_W-1), -1 if not taken (saturate at 0); target overwritten with update_target when taken.
REQ-023 Update on miss with update_taken=1: allocate (overwrite) indexed entry: valid=1, new tag, target=update_target, counter=2^(CNT_W-1) (weakly taken).
REQ-024 Update on miss with update_taken=0: no table change.
REQ-025 Mispredict on update: predicted-taken (hit and counter MSB) != update_taken, or both taken and stored target != update_target; miss with taken counts as mispredict.
REQ-026 hit_cnt/mispredict_cnt SHALL saturate at 2^32-1, never wrap.
REQ-027 Lookup and update to same entry in same cycle: lookup SHALL return pre-update state (no bypass); update takes effect next cycle.
REQ-028 clear and update_en together: clear wins; no allocation; counters hit_cnt/mispredict_cnt unaffected by clear.
REQ-029 Updates to different indices are independent; only one update per cycle.

Reset
REQ-030 nRST low SHALL immediately clear all valid bits, set all direction counters to 2^(CNT_W-1)-1 (weakly not-taken), zero targets/tags, zero hit_cnt and mispredict_cnt.
REQ-031 During and after reset with no updates: hit=0, predict_taken=0, pred_next_pc=lookup_pc+4.
REQ-032 Reset asserted mid-update: update discarded; state equals reset state.

Verification
REQ-033 Reset, lookup_pc=0x0000_0040 -> hit=0, predict_taken=0, pred_next_pc=0x0000_0044, counters 0.
REQ-034 Update pc=0x40 taken target=0x100, then lookup 0x40 -> hit=1, predict_taken=1, pred_next_pc=0x100; mispredict_cnt=1, hit_cnt=0.
REQ-035 Same entry, three not-taken updates -> counter 2->1->0->0 (saturated), lookup 0x40 gives predict_taken=0, pred_next_pc=0x44; hit_cnt=3, mispredict_cnt=2.
REQ-036 Aliasing (ENTRIES=16): entry at 0x40 valid, update pc=0x80 taken target=0x200 -> lookup 0x40 misses, lookup 0x80 hits with target 0x200.
REQ-037 Same-cycle lookup/update of 0x40 after allocation: lookup shows old target 0x100 while update writes 0x180; next cycle shows 0x180.
REQ-038 clear with simultaneous update_en taken pc=0x40 -> next cycle all lookups miss, no allocation; stat counters unchanged.
